// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter/sequencer for the byte-wide RAM port shared by
// instruction fetch (IF, 4-byte reads) and the store/load buffer (LS).
// Requests are split into byte beats; reads are assembled little-endian.
// Optional build macro MEM_CTRL_IO_STALL_EN: stores to the IO region
// (addr[17:16] == IO_MASK_HI) wait while io_buffer_full is high.
module mem_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [1:0]  IO_MASK_HI = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_d;
  logic        last_ls;   // last grant went to LS
  logic        owner_ls;  // current transfer belongs to LS
  logic        pend;      // a read beat was addressed in the previous cycle
  logic        wr_q;
  logic [1:0]  cnt;       // beat index currently on mem_a
  logic [1:0]  rcnt;      // index of the next read byte to capture
  logic [1:0]  n_m1;      // beats in transfer minus one
  logic [1:0]  ls_n_m1;
  logic [1:0]  cnt_nx;
  logic [31:0] dbuf;      // store data, or read bytes collected so far
  logic [31:0] rd_next;
  logic        ls_ok, grant_ls, grant_if, rd_last, wr_last, io_hold;

`ifdef MEM_CTRL_IO_STALL_EN
  assign ls_ok   = ls_req && !(ls_wr && io_buffer_full &&
                               (ls_addr[17:16] == IO_MASK_HI));
  assign io_hold = (state == WR) && io_buffer_full &&
                   (mem_a[17:16] == IO_MASK_HI);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign ls_ok     = ls_req;
  assign io_hold   = 1'b0;
`endif

  assign ls_n_m1 = (ls_size == 2'd0) ? 2'd0 : (ls_size == 2'd1) ? 2'd1 : 2'd3;
  assign cnt_nx  = cnt + 2'd1;
  // A stalled RAM drives no write; an IO-held beat is likewise suppressed.
  assign mem_wr  = wr_q && rdy_in && !io_hold;

  // Next-state logic: arbitration in IDLE, beat completion in RD/WR.
  always_comb begin
    state_d  = state;
    grant_ls = 1'b0;
    grant_if = 1'b0;
    rd_last  = 1'b0;
    wr_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!clear_in) begin
          if (ls_ok && (!if_req || !last_ls)) begin
            grant_ls = 1'b1;
            state_d  = ls_wr ? WR : RD;
          end else if (if_req) begin
            grant_if = 1'b1;
            state_d  = RD;
          end
        end
      end
      RD: begin
        rd_last = pend && (rcnt == n_m1);
        if (clear_in)     state_d = IDLE;
        else if (rd_last) state_d = DONE;
      end
      WR: begin
        wr_last = !io_hold && (cnt == n_m1);
        if (wr_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read assembly: the incoming byte merged into its little-endian lane.
  always_comb begin
    rd_next = dbuf;
    rd_next[{rcnt, 3'b000} +: 8] = mem_din;
  end

  // State register; rdy_in low freezes the whole block.
  always_ff @(posedge clk_in) begin
    if (!rst_in)     state <= IDLE;
    else if (rdy_in) state <= state_d;
  end

  // Datapath: latch request on grant, step beats, capture bytes, pulse done.
  // Because the RAM is also held while rdy_in is low, freezing here keeps the
  // current beat's address on mem_a and the pending byte lane intact.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      last_ls  <= 1'b1;
      owner_ls <= 1'b0;
      pend     <= 1'b0;
      wr_q     <= 1'b0;
      cnt      <= '0;
      rcnt     <= '0;
      n_m1     <= '0;
      dbuf     <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
    end else if (rdy_in) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      if (grant_ls || grant_if) begin
        last_ls  <= grant_ls;
        owner_ls <= grant_ls;
        pend     <= 1'b0;
        cnt      <= '0;
        rcnt     <= '0;
        n_m1     <= grant_ls ? ls_n_m1 : 2'd3;
        mem_a    <= grant_ls ? ls_addr : if_addr;
        dbuf     <= (grant_ls && ls_wr) ? ls_wdata : '0;
        wr_q     <= grant_ls && ls_wr;
        if (grant_ls && ls_wr) mem_dout <= ls_wdata[7:0];
      end else if (state == RD && !clear_in) begin
        pend <= 1'b1;
        if (cnt != n_m1) begin
          cnt   <= cnt_nx;
          mem_a <= mem_a + ADDR_W'(1);
        end
        if (pend) begin
          dbuf <= rd_next;
          rcnt <= rcnt + 2'd1;
        end
        if (rd_last) begin
          if (owner_ls) begin
            ls_done  <= 1'b1;
            ls_rdata <= rd_next;
          end else begin
            if_done <= 1'b1;
            if_data <= rd_next;
          end
        end
      end else if (state == WR && !io_hold) begin
        if (wr_last) begin
          wr_q    <= 1'b0;
          ls_done <= 1'b1;
        end else begin
          cnt      <= cnt_nx;
          mem_a    <= mem_a + ADDR_W'(1);
          mem_dout <= dbuf[{cnt_nx, 3'b000} +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Stimulus pushes the expected
// bus activity and done pulses; a negedge monitor pops and compares them.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        if_req, ls_req, ls_wr, io_full;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic        if_done, ls_done, mem_wr;
  logic [31:0] if_data, ls_rdata, mem_a;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  ram [0:1023];
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned errs = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    bit          is_if;
    bit          chk_data;
    logic [31:0] data;
  } done_t;

  obs_t  obs_q[$];
  done_t done_q[$];
  obs_t  mo;
  done_t md;

  mem_ctrl #(.ADDR_W(32), .IO_MASK_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .io_buffer_full(io_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM model: byte appears one cycle after its address; holds while not ready.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din <= ram[mem_a[9:0]];
      if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    end
  end

  // Monitor: bus beats and done pulses against the scoreboard queues.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (obs_q.size() > 0 && obs_q[0].cyc <= cyc) begin
        mo = obs_q.pop_front();
        vectors++;
        if (mo.cyc != cyc || mem_a !== mo.a || mem_wr !== mo.wr ||
            (mo.wr && mem_dout !== mo.d)) begin
          errs++;
          $display("FAIL bus @%0d: got a=%h wr=%b d=%h, want @%0d a=%h wr=%b d=%h",
                   cyc, mem_a, mem_wr, mem_dout, mo.cyc, mo.a, mo.wr, mo.d);
        end
      end else if (mem_wr) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_write @%0d: a=%h d=%h, want no write", cyc, mem_a, mem_dout);
      end
      if (if_done || ls_done) begin
        vectors++;
        if (done_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_done @%0d: if_done=%b ls_done=%b, want none",
                   cyc, if_done, ls_done);
        end else begin
          md = done_q.pop_front();
          if (md.cyc != cyc || if_done !== md.is_if || ls_done !== !md.is_if ||
              (md.chk_data && (md.is_if ? if_data : ls_rdata) !== md.data)) begin
            errs++;
            $display("FAIL done @%0d: got if=%b ls=%b if_data=%h ls_rdata=%h, want @%0d if=%b data=%h",
                     cyc, if_done, ls_done, if_data, ls_rdata, md.cyc, md.is_if, md.data);
          end
        end
      end else if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        md = done_q.pop_front();
        vectors++;
        errs++;
        $display("FAIL missing_done @%0d: got none, want done if=%b at %0d", cyc, md.is_if, md.cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic exp_bus(input int unsigned c, input logic [31:0] a,
                         input logic wr, input logic [7:0] d);
    obs_t o;
    o.cyc = c; o.a = a; o.wr = wr; o.d = d;
    obs_q.push_back(o);
  endtask

  task automatic exp_done(input int unsigned c, input bit is_if,
                          input bit chk_data, input logic [31:0] data);
    done_t e;
    e.cyc = c; e.is_if = is_if; e.chk_data = chk_data; e.data = data;
    done_q.push_back(e);
  endtask

  task automatic exp_read(input int unsigned g, input logic [31:0] base, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) exp_bus(g + k, base + k, 1'b0, 8'h00);
  endtask

  task automatic exp_write(input int unsigned g, input logic [31:0] base,
                           input int unsigned n, input logic [31:0] wd);
    for (int unsigned k = 0; k < n; k++) exp_bus(g + k, base + k, 1'b1, wd[8*k +: 8]);
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic ls_single(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp);
    int unsigned g, n, dc;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    g = cyc + 1;
    if (wr) begin
      exp_write(g, addr, n, wd);
      dc = g + n;
      exp_done(dc, 1'b0, 1'b0, 32'h0);
    end else begin
      exp_read(g, addr, n);
      dc = g + n + 1;
      exp_done(dc, 1'b0, 1'b1, exp);
    end
    ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wd;
    wait_cyc(dc);
    ls_req = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic if_single(input logic [31:0] addr, input logic [31:0] exp);
    int unsigned g;
    g = cyc + 1;
    exp_read(g, addr, 4);
    exp_done(g + 5, 1'b1, 1'b1, exp);
    if_req = 1'b1; if_addr = addr;
    wait_cyc(g + 5);
    if_req = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned g, c;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05;
    ram[10'h200] = 8'h11; ram[10'h201] = 8'h22; ram[10'h202] = 8'h33; ram[10'h203] = 8'h44;
    ram[10'h300] = 8'hA5;
    mem_din = 8'h00;
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_if_done", {31'h0, if_done}, 32'h0);
    chk("rst_ls_done", {31'h0, ls_done}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b1;
    mon_en = 1'b1;
    @(negedge clk_in);

    // stores: 2 bytes across 0x1FFFFFFF, and wrap at top of address space
    ls_single(1'b1, 2'd1, 32'h1FFF_FFFF, 32'hAABB_CCDD, 32'h0);
    ls_single(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_BEEF, 32'h0);
    // instruction fetch
    if_single(32'h0000_0100, 32'h0000_0513);

    // both requesting continuously: LS, IF, LS, IF
    g = cyc + 1;
    exp_read(g, 32'h300, 1);       exp_done(g + 2,  1'b0, 1'b1, 32'h0000_00A5);
    exp_read(g + 4, 32'h100, 4);   exp_done(g + 9,  1'b1, 1'b1, 32'h0000_0513);
    exp_read(g + 11, 32'h300, 1);  exp_done(g + 13, 1'b0, 1'b1, 32'h0000_00A5);
    exp_read(g + 15, 32'h100, 4);  exp_done(g + 20, 1'b1, 1'b1, 32'h0000_0513);
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h100;
    wait_cyc(g + 20);
    ls_req = 1'b0; if_req = 1'b0;
    @(negedge clk_in);

    // clear during IF read; a following store completes
    g = cyc + 1;
    exp_read(g, 32'h100, 3);
    exp_bus(g + 3, 32'h102, 1'b0, 8'h00);
    exp_write(g + 4, 32'h50, 1, 32'h77);
    exp_done(g + 5, 1'b0, 1'b0, 32'h0);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk_in);
    @(negedge clk_in);
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h50; ls_wdata = 32'h77;
    @(negedge clk_in);
    clear_in = 1'b1; if_req = 1'b0;
    @(negedge clk_in);
    clear_in = 1'b0;
    wait_cyc(g + 5);
    ls_req = 1'b0;
    @(negedge clk_in);

    // request together with clear in IDLE is ignored for that cycle
    c = cyc;
    exp_bus(c + 1, 32'h50, 1'b0, 8'h00);
    g = c + 2;
    exp_read(g, 32'h200, 2);
    exp_done(g + 3, 1'b0, 1'b1, 32'h0000_2211);
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h200;
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    wait_cyc(g + 3);
    ls_req = 1'b0;
    @(negedge clk_in);

    // 4-byte load with a 3-cycle RAM stall after the second beat
    g = cyc + 1;
    exp_bus(g, 32'h200, 1'b0, 8'h00);
    exp_bus(g + 1, 32'h201, 1'b0, 8'h00);
    for (int unsigned k = 2; k <= 5; k++) exp_bus(g + k, 32'h202, 1'b0, 8'h00);
    exp_bus(g + 6, 32'h203, 1'b0, 8'h00);
    exp_done(g + 8, 1'b0, 1'b1, 32'h4433_2211);
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
    wait_cyc(g + 2);
    rdy_in = 1'b0;
    wait_cyc(g + 5);
    rdy_in = 1'b1;
    wait_cyc(g + 8);
    ls_req = 1'b0;
    @(negedge clk_in);

    // IO-region store while the IO sink is full
`ifdef MEM_CTRL_IO_STALL_EN
    io_full = 1'b1;
    g = cyc + 6;
    exp_write(g, 32'h0003_0000, 1, 32'h5A);
    exp_done(g + 1, 1'b0, 1'b0, 32'h0);
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h5A;
    repeat (5) @(negedge clk_in);
    io_full = 1'b0;
    wait_cyc(g + 1);
    ls_req = 1'b0;
    @(negedge clk_in);
`else
    io_full = 1'b1;
    ls_single(1'b1, 2'd0, 32'h0003_0000, 32'h5A, 32'h0);
    io_full = 1'b0;
`endif

    // reset in the middle of an IF read: no done, outputs cleared
    if_req = 1'b1; if_addr = 32'h100;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0; if_req = 1'b0;
    @(negedge clk_in);
    chk("midrst_mem_a", mem_a, 32'h0);
    chk("midrst_if_data", if_data, 32'h0);
    chk("midrst_ls_rdata", ls_rdata, 32'h0);
    chk("midrst_if_done", {31'h0, if_done}, 32'h0);
    rst_in = 1'b1;
    repeat (8) @(negedge clk_in);
    if_single(32'h0000_0100, 32'h0000_0513);

    repeat (4) @(negedge clk_in);
    chk("pending_bus_expectations", obs_q.size(), 32'h0);
    chk("pending_done_expectations", done_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
